// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line into the receiver and received word/status out.
// master: drives RxD, observes results. slave: the receiver itself.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RxD;
    logic [DATA_WIDTH-1:0] RxData;
    logic                  valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output RxD,
        input  RxData,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  RxD,
        output RxData,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8E1-style receiver (start, data MSB-first, even parity, stop).
// Ports: clk, reset (async, active-low), bus (uart_rx_if.slave):
//   RxD in; RxData, valid, parity_err, frame_err, busy out.
// Option: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting per bit.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decision lands one cycle after the nominal sample point, so the
    // counter must reach CYCLES_PER_BIT and reloads with 1 to keep the
    // bit period unchanged.
    localparam int VOTE_LAG = 1;
    localparam int CW       = $clog2(CYCLES_PER_BIT + 1);
`else
    localparam int VOTE_LAG = 0;
    localparam int CW       = $clog2(CYCLES_PER_BIT);
`endif

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] START_HIT  = CW'(HALF_BIT - 1 + VOTE_LAG);
    localparam logic [CW-1:0] BIT_HIT    = CW'(CYCLES_PER_BIT - 1 + VOTE_LAG);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(VOTE_LAG);
    localparam logic [BW-1:0] LAST_IDX   = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  prev_q;
    logic                  rx_s;
    logic                  smp;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    assign rx_s = sync2_q;

    // Two-flop synchronizer plus one cycle of history for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.RxD;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic prev2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev2_q <= 1'b1;
        end else begin
            prev2_q <= prev_q;
        end
    end

    // At count target+1: prev2 = sample@target-1, prev = @target.
    assign smp = (prev2_q & prev_q)
               | (prev2_q & rx_s)
               | (prev_q  & rx_s);
`else
    assign smp = rx_s;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        rxdata_d = rxdata_q;
        valid_d  = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == START_HIT) begin
                    cnt_d   = CNT_RELOAD;
                    state_d = smp ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_HIT) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = (shift_q << 1) | DATA_WIDTH'(smp);
                    idx_d   = idx_q + BW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_HIT) begin
                    cnt_d   = CNT_RELOAD;
                    par_d   = smp;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a start edge in its second
                // half is caught from IDLE.
                if (cnt_q == BIT_HIT) begin
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    rxdata_d = shift_q;
                    perr_d   = (^shift_q) != par_q;
                    ferr_d   = !smp;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            rxdata_q <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            rxdata_q <= rxdata_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.RxData     = rxdata_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue-based receive model.
// Define UART_RX_MAJORITY_VOTE_EN to add mid-bit glitches to the last pair.
module tb_uart_rx;
    localparam int CPB  = 100_000_000 / 115_200;
    localparam int HALF = CPB / 2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (115_200),
        .DATA_WIDTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t       expq[$];
    logic [7:0] exp_d  = 8'h00;
    logic       exp_pe = 1'b0;
    logic       exp_fe = 1'b0;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Every cycle: a valid pulse must match the oldest outstanding frame,
    // and the visible word/flags must equal the last accepted frame.
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                e      = expq.pop_front();
                exp_d  = e.d;
                exp_pe = e.pe;
                exp_fe = e.fe;
            end
        end
        check("rxdata", {24'd0, bus.RxData}, {24'd0, exp_d});
        check("parity_err", {31'd0, bus.parity_err}, {31'd0, exp_pe});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, exp_fe});
    end

    task automatic hold(input logic v, input int n);
        bus.RxD = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_out(input logic v, input bit gl);
        if (gl) begin
            hold(v, HALF);
            hold(~v, 1);
            hold(v, CPB - HALF - 1);
        end else begin
            hold(v, CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input bit gl);
        exp_t e;
        e.d  = d;
        e.pe = (^d) != par;
        e.fe = !stp;
        expq.push_back(e);
        bit_out(1'b0, gl);
        for (int i = 7; i >= 0; i--) begin
            bit_out(d[i], gl);
        end
        bit_out(par, gl);
        bit_out(stp, gl);
        check("valid_seen", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        bus.RxD = 1'b1;
        reset   = 1'b1;
        #2;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rxdata", {24'd0, bus.RxData}, 32'h0);
        check("rst_valid", {31'd0, bus.valid}, 32'h0);
        check("rst_busy", {31'd0, bus.busy}, 32'h0);
        check("rst_perr", {31'd0, bus.parity_err}, 32'h0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 20);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_data", {24'd0, bus.RxData}, 32'hA5);
        check("a5_perr", {31'd0, bus.parity_err}, 32'h0);
        check("a5_ferr", {31'd0, bus.frame_err}, 32'h0);

        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        check("07_data", {24'd0, bus.RxData}, 32'h07);
        check("07_perr", {31'd0, bus.parity_err}, 32'h1);
        check("07_ferr", {31'd0, bus.frame_err}, 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3c_data", {24'd0, bus.RxData}, 32'h3C);
        check("3c_ferr", {31'd0, bus.frame_err}, 32'h1);
        hold(1'b1, CPB);

        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        check("11_data", {24'd0, bus.RxData}, 32'h11);
        check("11_ferr", {31'd0, bus.frame_err}, 32'h0);

        // False start: 100 low cycles, decision near cycle 436.
        hold(1'b0, 100);
        hold(1'b1, 330);
        check("fs_busy_430", {31'd0, bus.busy}, 32'h1);
        hold(1'b1, 15);
        check("fs_busy_445", {31'd0, bus.busy}, 32'h0);
        check("fs_data", {24'd0, bus.RxData}, 32'h11);
        hold(1'b1, 50);

        // Reset in the middle of data bit 4 of 0xFF.
        hold(1'b0, CPB);
        hold(1'b1, 4 * CPB + HALF);
        check("ab_busy", {31'd0, bus.busy}, 32'h1);
        reset = 1'b0;
        expq.delete();
        exp_d  = 8'h00;
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        hold(1'b1, 3);
        check("ab_rst_data", {24'd0, bus.RxData}, 32'h0);
        check("ab_rst_busy", {31'd0, bus.busy}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 2 * CPB);
        check("ab_idle_busy", {31'd0, bus.busy}, 32'h0);

        send_frame(8'h42, 1'b0, 1'b1, 1'b0);
        check("42_data", {24'd0, bus.RxData}, 32'h42);
        check("42_perr", {31'd0, bus.parity_err}, 32'h0);
        check("42_ferr", {31'd0, bus.frame_err}, 32'h0);

        // Back-to-back, no idle gap between frames.
        send_frame(8'h00, 1'b0, 1'b1, GLITCH);
        check("b2b_00", {24'd0, bus.RxData}, 32'h00);
        send_frame(8'hFF, 1'b0, 1'b1, GLITCH);
        check("b2b_ff", {24'd0, bus.RxData}, 32'hFF);
        check("b2b_perr", {31'd0, bus.parity_err}, 32'h0);
        check("b2b_ferr", {31'd0, bus.frame_err}, 32'h0);
        hold(1'b1, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
